// File: rtl/game_end_ctrl.sv
// game_end_ctrl: tracks both tanks' hit points with per-tank hit cooldowns and latches the
// WIN/LOSE result until the end-of-game overlay sends the player back to the menu.
module game_end_ctrl #(
  parameter int unsigned HP_MAX       = 5,
  parameter int unsigned HP_W         = 4,
  parameter int unsigned HIT_COOLDOWN = 6500000,
  parameter int unsigned CD_W         = 23
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            select,
  input  logic            hit_self,
  input  logic            hit_enemy,
  input  logic            back_to_menu,
  output logic [1:0]      game_end,
  output logic            game_over,
  output logic [HP_W-1:0] hp_self,
  output logic [HP_W-1:0] hp_enemy
);
  typedef enum logic [1:0] {IDLE, PLAY, WIN, LOSE} state_t;
  localparam logic [HP_W-1:0] HP_FULL = HP_W'(HP_MAX);
  localparam logic [CD_W-1:0] CD_LOAD = CD_W'(HIT_COOLDOWN);
  state_t          state_q, state_d;
  logic [HP_W-1:0] hp_self_q, hp_self_d, hp_enemy_q, hp_enemy_d;
  logic [CD_W-1:0] cd_self_q, cd_self_d, cd_enemy_q, cd_enemy_d;
  logic [1:0]      game_end_q, game_end_d;
  logic            game_over_q, game_over_d;
  logic            reload, cnt_self, cnt_enemy;
  always_comb begin
    reload      = back_to_menu || (state_q == PLAY && !select);
    cnt_self    = state_q == PLAY && hit_self && cd_self_q == '0;
    cnt_enemy   = state_q == PLAY && hit_enemy && cd_enemy_q == '0;
    // own destruction is checked first so a mutual kill resolves to LOSE
    state_d     = reload ? IDLE :
                  state_q == IDLE ? (select ? PLAY : IDLE) :
                  state_q != PLAY ? state_q :
                  (cnt_self && hp_self_q == HP_W'(1)) ? LOSE :
                  (cnt_enemy && hp_enemy_q == HP_W'(1)) ? WIN : PLAY;
    hp_self_d   = reload ? HP_FULL : hp_self_q - HP_W'(cnt_self);
    hp_enemy_d  = reload ? HP_FULL : hp_enemy_q - HP_W'(cnt_enemy);
    cd_self_d   = reload ? '0 : cnt_self ? CD_LOAD : cd_self_q - CD_W'(cd_self_q != '0);
    cd_enemy_d  = reload ? '0 : cnt_enemy ? CD_LOAD : cd_enemy_q - CD_W'(cd_enemy_q != '0);
    game_end_d  = state_d == WIN ? 2'd1 : state_d == LOSE ? 2'd2 : 2'd0;
    game_over_d = state_d == WIN || state_d == LOSE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      hp_self_q   <= HP_FULL;
      hp_enemy_q  <= HP_FULL;
      cd_self_q   <= '0;
      cd_enemy_q  <= '0;
      game_end_q  <= 2'd0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      hp_self_q   <= hp_self_d;
      hp_enemy_q  <= hp_enemy_d;
      cd_self_q   <= cd_self_d;
      cd_enemy_q  <= cd_enemy_d;
      game_end_q  <= game_end_d;
      game_over_q <= game_over_d;
    end
  end
  assign game_end  = game_end_q;
  assign game_over = game_over_q;
  assign hp_self   = hp_self_q;
  assign hp_enemy  = hp_enemy_q;
endmodule

// File: tb/tb_game_end_ctrl.sv
// tb_game_end_ctrl: directed scenarios plus randomized traffic against a cycle-count based game model.
module tb_game_end_ctrl;
  localparam int HC = 100;
  localparam int HPM = 5;
  localparam int M_MENU = 0, M_GAME = 1, M_WON = 2, M_LOST = 3;
  logic clk = 1'b0, rst = 1'b1, select = 1'b0, hit_self = 1'b0, hit_enemy = 1'b0, back_to_menu = 1'b0;
  logic [1:0] game_end;
  logic game_over;
  logic [3:0] hp_self, hp_enemy;
  int checks = 0, failures = 0;
  int m_mode = M_MENU, m_hs = HPM, m_he = HPM;
  longint m_cyc = 0, m_last_s = -1000000, m_last_e = -1000000;

  game_end_ctrl #(.HP_MAX(HPM), .HP_W(4), .HIT_COOLDOWN(HC), .CD_W(8)) dut (
    .clk(clk), .rst(rst), .select(select), .hit_self(hit_self), .hit_enemy(hit_enemy),
    .back_to_menu(back_to_menu), .game_end(game_end), .game_over(game_over),
    .hp_self(hp_self), .hp_enemy(hp_enemy));

  always #5 clk = ~clk;

  task automatic model_reload(input int mode);
    m_mode = mode; m_hs = HPM; m_he = HPM; m_last_s = -1000000; m_last_e = -1000000;
  endtask

  // A tank accepts a hit only if more than HC cycles have passed since its last counted hit.
  task automatic model_edge(input bit r, s, hs, he, b);
    bit ok_s, ok_e;
    if (r) model_reload(M_MENU);
    else if (b || (m_mode == M_GAME && !s)) model_reload(M_MENU);
    else if (m_mode == M_MENU) m_mode = s ? M_GAME : M_MENU;
    else if (m_mode == M_GAME) begin
      ok_s = hs && (m_cyc - m_last_s > HC);
      ok_e = he && (m_cyc - m_last_e > HC);
      if (ok_s) begin m_hs--; m_last_s = m_cyc; end
      if (ok_e) begin m_he--; m_last_e = m_cyc; end
      if (m_hs == 0) m_mode = M_LOST;
      else if (m_he == 0) m_mode = M_WON;
    end
    m_cyc++;
  endtask

  function automatic logic [10:0] exp_vec();
    logic [1:0] e;
    e = m_mode == M_WON ? 2'd1 : m_mode == M_LOST ? 2'd2 : 2'd0;
    return {e, m_mode >= M_WON, 4'(m_hs), 4'(m_he)};
  endfunction

  task automatic step(input bit r, s, hs, he, b);
    rst = r; select = s; hit_self = hs; hit_enemy = he; back_to_menu = b;
    @(posedge clk);
    model_edge(r, s, hs, he, b);
    #1;
  endtask

  task automatic idle(input int n, input bit s);
    repeat (n) step(0, s, 0, 0, 0);
  endtask

  task automatic test_reset;
    step(1, 0, 0, 0, 0); step(1, 1, 1, 1, 0);
    checks++;
    if ({game_end, game_over, hp_self, hp_enemy} !== {2'd0, 1'b0, 4'd5, 4'd5}) begin
      failures++; $display("FAIL reset: got end=%0d over=%0b hp=%0d/%0d want 0 0 5/5", game_end, game_over, hp_self, hp_enemy);
    end
    step(0, 0, 1, 1, 0);
    checks++;
    if ({hp_self, hp_enemy, game_end} !== {4'd5, 4'd5, 2'd0}) begin
      failures++; $display("FAIL idle_hits_ignored: got hp=%0d/%0d end=%0d want 5/5 0", hp_self, hp_enemy, game_end);
    end
  endtask

  task automatic test_win_sequence;
    step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step(0, 1, 0, 1, 0);
      checks++;
      if (hp_enemy !== 4'(4 - i) || exp_vec() !== {game_end, game_over, hp_self, hp_enemy}) begin
        failures++; $display("FAIL win_hp_enemy[%0d]: got %0d want %0d", i, hp_enemy, 4 - i);
      end
      if (i < 4) idle(HC + 10, 1);
    end
    checks++;
    if (game_end !== 2'd1 || game_over !== 1'b1) begin
      failures++; $display("FAIL win_latch: got end=%0d over=%0b want 1 1", game_end, game_over);
    end
  endtask

  task automatic test_cooldown;
    step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0);
    checks++;
    if (hp_self !== 4'd4) begin failures++; $display("FAIL cd_first: got %0d want 4", hp_self); end
    idle(9, 1); step(0, 1, 1, 0, 0);
    checks++;
    if (hp_self !== 4'd4) begin failures++; $display("FAIL cd_dropped: got %0d want 4", hp_self); end
    idle(89, 1); step(0, 1, 1, 0, 0);
    checks++;
    if (hp_self !== 4'd4) begin failures++; $display("FAIL cd_edge100: got %0d want 4", hp_self); end
    step(0, 1, 1, 0, 0);
    checks++;
    if (hp_self !== 4'd3) begin failures++; $display("FAIL cd_expired: got %0d want 3", hp_self); end
  endtask

  task automatic test_double_kill;
    step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0);
    repeat (4) begin step(0, 1, 1, 1, 0); idle(HC + 5, 1); end
    checks++;
    if ({hp_self, hp_enemy, game_end} !== {4'd1, 4'd1, 2'd0}) begin
      failures++; $display("FAIL dk_setup: got hp=%0d/%0d end=%0d want 1/1 0", hp_self, hp_enemy, game_end);
    end
    step(0, 1, 1, 1, 0);
    checks++;
    if ({game_end, game_over, hp_self, hp_enemy} !== {2'd2, 1'b1, 4'd0, 4'd0}) begin
      failures++; $display("FAIL double_kill: got end=%0d over=%0b hp=%0d/%0d want 2 1 0/0", game_end, game_over, hp_self, hp_enemy);
    end
  endtask

  task automatic test_frozen;
    step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0);
    repeat (5) begin step(0, 1, 0, 1, 0); idle(HC + 5, 1); end
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0, 0); idle(3, 0);
      checks++;
      if ({game_end, game_over, hp_self, hp_enemy} !== {2'd1, 1'b1, 4'd5, 4'd0}) begin
        failures++; $display("FAIL frozen[%0d]: got end=%0d over=%0b hp=%0d/%0d want 1 1 5/0", i, game_end, game_over, hp_self, hp_enemy);
      end
    end
    step(0, 0, 0, 0, 1);
    checks++;
    if ({game_end, game_over, hp_self, hp_enemy} !== {2'd0, 1'b0, 4'd5, 4'd5}) begin
      failures++; $display("FAIL back_to_menu: got end=%0d over=%0b hp=%0d/%0d want 0 0 5/5", game_end, game_over, hp_self, hp_enemy);
    end
    step(0, 1, 0, 0, 0); step(0, 1, 1, 0, 0);
    checks++;
    if (hp_self !== 4'd4 || game_end !== 2'd0) begin
      failures++; $display("FAIL replay: got hp_self=%0d end=%0d want 4 0", hp_self, game_end);
    end
  endtask

  task automatic test_deselect;
    step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0);
    step(0, 1, 1, 0, 0); idle(HC + 5, 1); step(0, 1, 1, 0, 0); idle(HC + 5, 1); step(0, 1, 1, 0, 0);
    checks++;
    if (hp_self !== 4'd2) begin failures++; $display("FAIL desel_setup: got %0d want 2", hp_self); end
    step(0, 0, 0, 0, 0);
    checks++;
    if (hp_self !== 4'd5 || game_end !== 2'd0) begin
      failures++; $display("FAIL deselect: got hp_self=%0d end=%0d want 5 0", hp_self, game_end);
    end
    step(0, 1, 0, 0, 0); step(0, 1, 1, 0, 0);
    checks++;
    if (hp_self !== 4'd4) begin failures++; $display("FAIL desel_cd_clear: got %0d want 4", hp_self); end
  endtask

  task automatic test_rst_in_lose;
    step(1, 0, 0, 0, 0); step(0, 1, 0, 0, 0);
    repeat (4) begin step(0, 1, 1, 0, 0); idle(HC + 5, 1); end
    step(0, 1, 1, 0, 0); idle(2, 1);
    checks++;
    if (game_end !== 2'd2 || game_over !== 1'b1) begin
      failures++; $display("FAIL lose_latch: got end=%0d over=%0b want 2 1", game_end, game_over);
    end
    step(1, 1, 1, 0, 0);
    checks++;
    if ({game_end, game_over, hp_self, hp_enemy} !== {2'd0, 1'b0, 4'd5, 4'd5}) begin
      failures++; $display("FAIL rst_in_lose: got end=%0d over=%0b hp=%0d/%0d want 0 0 5/5", game_end, game_over, hp_self, hp_enemy);
    end
    step(0, 1, 0, 0, 0); step(0, 1, 1, 0, 0);
    checks++;
    if (hp_self !== 4'd4) begin failures++; $display("FAIL rst_cd_clear: got %0d want 4", hp_self); end
  endtask

  task automatic test_random;
    bit s = 1'b1;
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 149) == 0) s = ~s;
      step($urandom_range(0, 999) == 0, s, $urandom_range(0, 24) == 0, $urandom_range(0, 24) == 0,
           $urandom_range(0, 399) == 0);
      checks++;
      if ({game_end, game_over, hp_self, hp_enemy} !== exp_vec()) begin
        failures++;
        $display("FAIL random[%0d]: got {end,over,hp_s,hp_e}=%h want %h", i, {game_end, game_over, hp_self, hp_enemy}, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset;
    test_win_sequence;
    test_cooldown;
    test_double_kill;
    test_frozen;
    test_deselect;
    test_rst_in_lose;
    test_random;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
